// File: rtl/vga_timing_pkg.sv
// Shared VGA mode table and helpers for the multi-mode timing engine.
// Each entry holds porch/sync sizes, sync polarity and the pixel-rate phase step.
package vga_timing_pkg;

  localparam int NUM_MODES = 4;
  localparam int TIM_W     = 11;

  typedef struct packed {
    logic [TIM_W-1:0] hd;
    logic [TIM_W-1:0] hf;
    logic [TIM_W-1:0] hr;
    logic [TIM_W-1:0] hb;
    logic [TIM_W-1:0] vd;
    logic [TIM_W-1:0] vf;
    logic [TIM_W-1:0] vr;
    logic [TIM_W-1:0] vb;
    logic             pol;   // 1: active-high syncs
    logic [15:0]      step;
  } vga_mode_t;

  localparam vga_mode_t MODE_TABLE [NUM_MODES] = '{
    '{11'd640,  11'd16, 11'd96,  11'd48,  11'd480, 11'd10, 11'd2, 11'd33, 1'b0, 16'h338F},
    '{11'd800,  11'd40, 11'd128, 11'd88,  11'd600, 11'd1,  11'd4, 11'd23, 1'b1, 16'h51EC},
    '{11'd1024, 11'd24, 11'd136, 11'd160, 11'd768, 11'd3,  11'd6, 11'd29, 1'b0, 16'h851F},
    '{11'd1366, 11'd70, 11'd143, 11'd213, 11'd768, 11'd3,  11'd3, 11'd24, 1'b1, 16'hAF1B}
  };

  function automatic logic [TIM_W-1:0] total_h(input logic [1:0] mode);
    return MODE_TABLE[mode].hd + MODE_TABLE[mode].hf + MODE_TABLE[mode].hr + MODE_TABLE[mode].hb;
  endfunction

  function automatic logic [TIM_W-1:0] total_v(input logic [1:0] mode);
    return MODE_TABLE[mode].vd + MODE_TABLE[mode].vf + MODE_TABLE[mode].vr + MODE_TABLE[mode].vb;
  endfunction

  function automatic logic in_span(input logic [TIM_W-1:0] pos, input logic [TIM_W-1:0] lo,
                                   input logic [TIM_W-1:0] len);
    return (pos >= lo) && (pos < (lo + len));
  endfunction

endpackage

// File: rtl/vga_frac_stb.sv
// Fractional pixel-rate generator: phase accumulator whose carry is the pixel enable.
// adv_o is the carry in the cycle it is produced; stb_o is the same pulse registered.
module vga_frac_stb #(
  parameter int ACC_W = 16
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             en_i,
  input  logic [ACC_W-1:0] step_i,
  output logic             adv_o,
  output logic             stb_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             stb_q, stb_d;
  logic [ACC_W:0]   sum_s;

  // Next accumulator phase and carry; everything holds while disabled.
  always_comb begin
    sum_s = {1'b0, acc_q} + {1'b0, step_i};
    if (en_i) begin
      acc_d = sum_s[ACC_W-1:0];
      stb_d = sum_s[ACC_W];
    end else begin
      acc_d = acc_q;
      stb_d = 1'b0;
    end
  end

  // Accumulator and strobe registers.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      acc_q <= '0;
      stb_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      stb_q <= stb_d;
    end
  end

  assign adv_o = stb_d;
  assign stb_o = stb_q;

endmodule

// File: rtl/vga_mode_timing_gen.sv
// Multi-mode VGA timing engine: counters, DE, syncs and frame/line markers on a fractional
// pixel enable, with runtime mode changes deferred to the frame boundary.
module vga_mode_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CNT_W        = 11,
  parameter int ACC_W        = 16,
  parameter int DEFAULT_MODE = 0
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic             mode_valid_i,
  output logic             mode_ready_o,
  output logic [1:0]       mode_o,
  output logic             pix_stb_o,
  output logic [CNT_W-1:0] hcount_o,
  output logic [CNT_W-1:0] vcount_o,
  output logic             de_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             sof_o,
  output logic             eol_o
);

  localparam logic [1:0]       DEF_MODE   = 2'(DEFAULT_MODE);
  localparam logic [CNT_W-1:0] DEF_H_LAST = CNT_W'(total_h(DEF_MODE) - 11'd1);
  localparam logic [CNT_W-1:0] DEF_V_LAST = CNT_W'(total_v(DEF_MODE) - 11'd1);
  localparam logic             DEF_POL    = MODE_TABLE[DEF_MODE].pol;

  logic             adv_s, accept_s, h_last_s, v_last_s, wrap_s;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [1:0]       mode_q, mode_d, pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d, ready_q, ready_d;
  logic             de_q, de_d, hs_q, hs_d, vs_q, vs_d, sof_q, sof_d, eol_q, eol_d;

  // The step follows the active mode, so a new mode's rate starts right after its (0,0).
  vga_frac_stb #(
    .ACC_W(ACC_W)
  ) u_stb (
    .clk_i  (clk_i),
    .arstn_i(arstn_i),
    .en_i   (en_i),
    .step_i (ACC_W'(MODE_TABLE[mode_q].step)),
    .adv_o  (adv_s),
    .stb_o  (pix_stb_o)
  );

  // Counter advance, mode handshake and output decode from the next-state counters.
  always_comb begin
    hcnt_d     = hcnt_q;
    vcnt_d     = vcnt_q;
    mode_d     = mode_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ready_d    = ready_q;
    accept_s   = mode_valid_i && ready_q;
    h_last_s   = (TIM_W'(hcnt_q) == (total_h(mode_q) - 11'd1));
    v_last_s   = (TIM_W'(vcnt_q) == (total_v(mode_q) - 11'd1));
    wrap_s     = adv_s && h_last_s && v_last_s;

    if (adv_s) begin
      if (h_last_s) begin
        hcnt_d = '0;
        vcnt_d = v_last_s ? '0 : (vcnt_q + CNT_W'(1));
      end else begin
        hcnt_d = hcnt_q + CNT_W'(1);
      end
    end else begin
      hcnt_d = hcnt_q;
    end

    // Ready is blocked while a request is pending and for one clock after it is applied.
    if (accept_s) begin
      pend_d     = mode_i;
      pend_vld_d = 1'b1;
      ready_d    = 1'b0;
    end else if (wrap_s && pend_vld_q) begin
      mode_d     = pend_q;
      pend_vld_d = 1'b0;
    end else begin
      ready_d = !pend_vld_q;
    end

    de_d  = (TIM_W'(hcnt_d) < MODE_TABLE[mode_d].hd) && (TIM_W'(vcnt_d) < MODE_TABLE[mode_d].vd);
    hs_d  = in_span(TIM_W'(hcnt_d), MODE_TABLE[mode_d].hd + MODE_TABLE[mode_d].hf,
                    MODE_TABLE[mode_d].hr) ? MODE_TABLE[mode_d].pol : !MODE_TABLE[mode_d].pol;
    vs_d  = in_span(TIM_W'(vcnt_d), MODE_TABLE[mode_d].vd + MODE_TABLE[mode_d].vf,
                    MODE_TABLE[mode_d].vr) ? MODE_TABLE[mode_d].pol : !MODE_TABLE[mode_d].pol;
    sof_d = wrap_s;
    eol_d = adv_s && (TIM_W'(hcnt_d) == (total_h(mode_d) - 11'd1));
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      hcnt_q     <= DEF_H_LAST;
      vcnt_q     <= DEF_V_LAST;
      mode_q     <= DEF_MODE;
      pend_q     <= DEF_MODE;
      pend_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      de_q       <= 1'b0;
      hs_q       <= !DEF_POL;
      vs_q       <= !DEF_POL;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
    end else begin
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      mode_q     <= mode_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ready_q    <= ready_d;
      de_q       <= de_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      sof_q      <= sof_d;
      eol_q      <= eol_d;
    end
  end

  assign hcount_o     = hcnt_q;
  assign vcount_o     = vcnt_q;
  assign mode_o       = mode_q;
  assign mode_ready_o = ready_q;
  assign de_o         = de_q;
  assign hsync_o      = hs_q;
  assign vsync_o      = vs_q;
  assign sof_o        = sof_q;
  assign eol_o        = eol_q;

endmodule
